// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin arbiters on the 16-lane datapath.
package mux_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_n.sv
// 16:1 lane selector with a 4-bit select; purely combinational.
module mux_n
    import mux_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic [NREQ*DW-1:0] din,
    output logic [DW-1:0]      dout
);

    logic [DW-1:0] lane [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane[gi] = din[DW*gi +: DW];
        end
    endgenerate

    assign dout = lane[sel];

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler: captures one requester lane per grant and holds it
// until the consumer accepts, re-arbitrating on the accept cycle.
module mux_rr_sched
    import mux_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               busy
);

    state_t             state_reg;
    logic [SEL_W-1:0]   ptr_reg;
    logic [NREQ-1:0]    gnt_reg;
    logic               out_valid_reg;
    logic [DW-1:0]      out_data_reg;
    logic [SEL_W-1:0]   out_src_reg;

    logic               accept;
    logic               arb;
    logic [SEL_W-1:0]   base;
    logic [SEL_W-1:0]   start;
    logic [2*NREQ-1:0]  dbl;
    logic [NREQ-1:0]    rot;
    logic [SEL_W-1:0]   off;
    logic [SEL_W-1:0]   winner;
    logic [DW-1:0]      lane_data;

    assign accept = out_valid_reg && out_ready;

    // On an accept the new pointer is the word just delivered, so scan from there.
    assign base  = (state_reg == SEND) ? out_src_reg : ptr_reg;
    assign start = base + 1'b1;
    assign dbl   = {req, req};
    assign rot   = dbl[start +: NREQ];

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign winner = start + off;

    always_comb begin
        arb = 1'b0;
        if (state_reg == IDLE) begin
            arb = |req;
        end else begin
            arb = accept && |(req & ~onehot(out_src_reg));
        end
    end

    mux_n #(.DW(DW)) u_mux (
        .sel  (winner),
        .din  (din),
        .dout (lane_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= 4'd15;
            gnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else begin
            gnt_reg <= arb ? onehot(winner) : '0;
            if (accept) begin
                ptr_reg <= out_src_reg;
            end
            if (arb) begin
                state_reg     <= SEND;
                out_valid_reg <= 1'b1;
                out_data_reg  <= lane_data;
                out_src_reg   <= winner;
            end else if ((state_reg == SEND) && accept) begin
                state_reg     <= IDLE;
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign gnt       = gnt_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign busy      = (state_reg == SEND);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed self-checking bench for the round-robin scheduler.
module tb_mux_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [63:0] din;
    logic [15:0] gnt;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [3:0]  out_src;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mux_rr_sched #(.DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp_v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] e_gnt;
        int          e_src;

        rst = 1'b1; req = '0; din = '0; out_ready = 1'b0;
        step();
        step();
        $display("reset: gnt=%h out_valid=%b out_data=%h out_src=%0d busy=%b", gnt, out_valid, out_data, out_src, busy);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_src", 32'(out_src), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Single request from lane 0.
        req = 16'h0001; din[3:0] = 4'hD;
        step();
        $display("single: gnt=%h out_valid=%b out_data=%h out_src=%0d", gnt, out_valid, out_data, out_src);
        chk("single_gnt", 32'(gnt), 32'h0001);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'hD);
        chk("single_src", 32'(out_src), 32'h0);
        chk("single_busy", 32'(busy), 32'h1);
        req = '0; out_ready = 1'b1;
        step();
        $display("single accept: out_valid=%b gnt=%h", out_valid, gnt);
        chk("single_acc_valid", 32'(out_valid), 32'h0);
        chk("single_acc_gnt", 32'(gnt), 32'h0);

        // Fairness: all requests held, one word per cycle in strict order.
        do_reset();
        for (int i = 0; i < 16; i++) din[4*i +: 4] = 4'(i);
        req = 16'hFFFF; out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            e_src = k % 16;
            e_gnt = 16'h0001 << e_src;
            $display("rr k=%0d: out_src=%0d gnt=%h out_data=%h", k, out_src, gnt, out_data);
            chk("rr_src", 32'(out_src), 32'(e_src));
            chk("rr_gnt", 32'(gnt), 32'(e_gnt));
            chk("rr_data", 32'(out_data), 32'(e_src));
        end
        req = '0;
        step();
        chk("rr_idle_valid", 32'(out_valid), 32'h0);

        // Wrap-around from ptr=15 with requesters 0 and 15.
        do_reset();
        req = 16'h8001; out_ready = 1'b1;
        step();
        $display("wrap 1: out_src=%0d gnt=%h", out_src, gnt);
        chk("wrap_src0", 32'(out_src), 32'd0);
        step();
        $display("wrap 2: out_src=%0d gnt=%h", out_src, gnt);
        chk("wrap_src15", 32'(out_src), 32'd15);
        chk("wrap_gnt15", 32'(gnt), 32'h8000);
        step();
        $display("wrap 3: out_src=%0d gnt=%h", out_src, gnt);
        chk("wrap_src0b", 32'(out_src), 32'd0);
        req = '0;
        step();
        chk("wrap_idle", 32'(out_valid), 32'h0);

        // Backpressure: held word stable while lane 5 changes.
        req = 16'h0020; din[23:20] = 4'hA; out_ready = 1'b0;
        step();
        $display("hold capture: out_src=%0d out_data=%h gnt=%h", out_src, out_data, gnt);
        chk("hold_src", 32'(out_src), 32'd5);
        chk("hold_data0", 32'(out_data), 32'hA);
        chk("hold_gnt0", 32'(gnt), 32'h0020);
        req = '0; din[23:20] = 4'h3;
        for (int c = 0; c < 6; c++) begin
            step();
            $display("hold cyc %0d: out_data=%h gnt=%h out_valid=%b", c, out_data, gnt, out_valid);
            chk("hold_data", 32'(out_data), 32'hA);
            chk("hold_gnt", 32'(gnt), 32'h0);
            chk("hold_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        step();
        $display("hold accept: out_valid=%b gnt=%h", out_valid, gnt);
        chk("hold_acc_valid", 32'(out_valid), 32'h0);
        chk("hold_acc_gnt", 32'(gnt), 32'h0);
        out_ready = 1'b0;

        // Reset while holding requester 7's word.
        req = 16'h0080; din[31:28] = 4'h7;
        step();
        chk("rstsend_src", 32'(out_src), 32'd7);
        chk("rstsend_gnt", 32'(gnt), 32'h0080);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0;
        $display("rst in SEND: out_valid=%b gnt=%h busy=%b out_src=%0d", out_valid, gnt, busy, out_src);
        chk("rstsend_valid", 32'(out_valid), 32'h0);
        chk("rstsend_gnt0", 32'(gnt), 32'h0);
        chk("rstsend_busy", 32'(busy), 32'h0);
        req = 16'hFFFF; out_ready = 1'b0;
        step();
        $display("after rst: out_src=%0d gnt=%h", out_src, gnt);
        chk("rstsend_ptr", 32'(out_src), 32'd0);
        chk("rstsend_gntp", 32'(gnt), 32'h0001);
        req = '0; out_ready = 1'b1;
        step();
        chk("rstsend_idle", 32'(out_valid), 32'h0);

        // A short-lived request during SEND leaves nothing behind.
        req = 16'h0004; din[11:8] = 4'h2; out_ready = 1'b0;
        step();
        chk("glitch_src", 32'(out_src), 32'd2);
        req = 16'h0008;
        step();
        chk("glitch_gnt_a", 32'(gnt), 32'h0);
        req = '0;
        step();
        out_ready = 1'b1;
        step();
        $display("glitch accept: out_valid=%b gnt=%h", out_valid, gnt);
        chk("glitch_valid", 32'(out_valid), 32'h0);
        step();
        chk("glitch_gnt_b", 32'(gnt), 32'h0);
        chk("glitch_valid_b", 32'(out_valid), 32'h0);

        // Sole requester equal to ptr wins again.
        req = 16'h0004;
        step();
        chk("self_src", 32'(out_src), 32'd2);
        chk("self_gnt", 32'(gnt), 32'h0004);
        step();
        chk("self_idle", 32'(out_valid), 32'h0);
        step();
        $display("self regrant: out_src=%0d gnt=%h", out_src, gnt);
        chk("self_regnt", 32'(gnt), 32'h0004);
        chk("self_src2", 32'(out_src), 32'd2);
        req = '0;
        step();
        chk("self_end", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
